// File: rtl/mm_tile_sequencer.sv
// Purpose: steps the SxS systolic core through its four tiles, captures each tile's
//          result bus into a buffer, then streams all 4*S*S elements out in index order.
// Latency: start to first out_valid = 1 + 4*(RST_CYCLES+COMPUTE_CYCLES+1) cycles.
// Backpressure: out_valid/out_ready; the held beat (data/index/last) is frozen while stalled.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start / busy / done run request, in-progress flag, end-of-run pulse
//   core_rst, sel1/sel2 core reset and tile select ({sel1,sel2} = tile number)
//   core_data           core result bus, element 0 in MSBs, row-major
//   out_*               result stream, one M-bit element per beat
module mm_tile_sequencer #(
  parameter int M              = 6,
  parameter int S              = 4,
  parameter int RST_CYCLES     = 2,
  parameter int COMPUTE_CYCLES = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        core_rst,
  output logic                        sel1,
  output logic                        sel2,
  input  logic [S*S*M-1:0]            core_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [M-1:0]                out_data,
  output logic [$clog2(4*S*S)-1:0]    out_index,
  output logic                        out_last
);

  localparam int NE = S*S;          // elements per tile
  localparam int NB = 4*NE;         // elements in the full result
  localparam int IW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DRAIN, FIN} state_t;

  state_t        state;
  logic [1:0]    tile;
  logic [15:0]   cnt;
  logic [M-1:0]  rbuf [NB];
  logic [IW-1:0] nidx;

  // tile doubles as the select register, so sel only moves when tile does
  // (on entry to CLEAR) and stays put through RUN and CAPTURE.
  assign sel1 = tile[1];
  assign sel2 = tile[0];
  assign nidx = out_index + IW'(1);

  // Result buffer: no reset, every slot is rewritten before the drain reads it.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      for (int e = 0; e < NE; e++) begin
        rbuf[IW'(int'(tile)*NE + e)] <= core_data[(NE-1-e)*M +: M];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tile      <= 2'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      core_rst  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          core_rst <= 1'b1;
          if (start) begin
            state <= CLEAR;
            tile  <= 2'd0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == 16'(RST_CYCLES-1)) begin
            state    <= RUN;
            core_rst <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RUN: begin
          // core_rst stays low through CAPTURE so the bus is sampled
          // exactly COMPUTE_CYCLES after the core left reset.
          if (cnt == 16'(COMPUTE_CYCLES-1)) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CAPTURE: begin
          core_rst <= 1'b1;
          cnt      <= '0;
          if (tile != 2'd3) begin
            tile  <= tile + 2'd1;
            state <= CLEAR;
          end else begin
            // Slot 0 was filled three tiles ago, so it is safe to read
            // while slot 3 is being written on this same edge.
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_index <= '0;
            out_data  <= rbuf[0];
            out_last  <= (NB == 1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= FIN;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_index <= nidx;
              out_data  <= rbuf[nidx];
              out_last  <= (nidx == IW'(NB-1));
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// Purpose: directed self-checking bench for mm_tile_sequencer with a behavioural core model.
// Latency: checks start-to-first-beat timing and per-tile core_rst/sel sequencing.
// Backpressure: drives out_ready always-high or in a 1,0,0 pattern and checks held beats.
module tb_mm_tile_sequencer;

  localparam int M    = 6;
  localparam int S    = 4;
  localparam int RSTC = 2;
  localparam int COMP = 20;
  localparam int NE   = S*S;
  localparam int NB   = 4*NE;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic            core_rst;
  logic            sel1;
  logic            sel2;
  logic [NE*M-1:0] core_data;
  logic            out_valid;
  logic            out_ready;
  logic [M-1:0]    out_data;
  logic [5:0]      out_index;
  logic            out_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mm_tile_sequencer #(.M(M), .S(S), .RST_CYCLES(RSTC), .COMPUTE_CYCLES(COMP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .core_rst(core_rst), .sel1(sel1), .sel2(sel2), .core_data(core_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  // Core model: counts cycles out of reset; the result bus carries the tile's
  // real values only in the cycle exactly COMP cycles after release, otherwise
  // a pattern that never matches any real element.
  logic [7:0] ccnt;
  always @(posedge clk) begin
    if (core_rst) ccnt <= 8'd0;
    else if (ccnt != 8'hFF) ccnt <= ccnt + 8'd1;
  end

  always_comb begin
    core_data = '0;
    for (int e = 0; e < NE; e++) begin
      if (ccnt == 8'(COMP))
        core_data[(NE-1-e)*M +: M] = 6'((int'({sel1, sel2})*16 + e) % 64);
      else
        core_data[(NE-1-e)*M +: M] = 6'(e ^ 6'h25);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One run: start pulse, then cycle-by-cycle monitoring sampled on the falling edge.
  // rmode 0 = always ready, 1 = ready pattern 1,0,0; inj = extra start pulses in
  // RUN of tile 1 and in DRAIN; abort_cyc > 0 = rst pulse in that cycle.
  task automatic do_pass(input int rmode, input int inj, input int abort_cyc);
    int         cyc = 0, nbeats = 0, ndone = 0, first_v = -1, nfall = 0, hi_len = 0, post = 0;
    logic       prev_crst;
    logic [1:0] sels [4];
    logic       hold = 1'b0;
    logic [5:0] h_dat = '0, h_idx = '0;
    logic       h_last = 1'b0;
    bit         fin = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    prev_crst = core_rst;
    hi_len    = core_rst ? 1 : 0;
    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start     = (inj != 0) && (cyc == 30 || cyc == 100);
      rst       = (abort_cyc > 0) && (cyc == abort_cyc);
      out_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        check("abort core_rst", core_rst, 1);
        check("abort sel", {sel1, sel2}, 0);
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        check("abort out_last", out_last, 0);
        check("abort done", done, 0);
        fin = 1'b1;
      end else begin
        if (prev_crst && !core_rst) begin
          if (nfall < 4) sels[nfall] = {sel1, sel2};
          if (nfall > 0) check("core_rst high len", hi_len, RSTC);
          nfall++;
        end
        hi_len    = core_rst ? hi_len + 1 : 0;
        prev_crst = core_rst;
        if (out_valid && first_v < 0) first_v = cyc;
        if (hold) begin
          check("stall valid", out_valid, 1);
          check("stall data", out_data, h_dat);
          check("stall index", out_index, h_idx);
          check("stall last", out_last, h_last);
        end
        hold   = out_valid && !out_ready;
        h_dat  = out_data;
        h_idx  = out_index;
        h_last = out_last;
        if (out_valid && out_ready) begin
          check("beat index", out_index, nbeats);
          check("beat data", out_data, nbeats % 64);
          check("beat last", out_last, nbeats == NB-1);
          nbeats++;
        end
        if (done) begin
          ndone++;
          check("beats at done", nbeats, NB);
        end
        if (ndone > 0) begin
          check("post busy", busy, 0);
          check("post out_valid", out_valid, 0);
          post++;
          if (post == 5) fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    if (abort_cyc == 0) begin
      check("pass ended", fin, 1);
      check("first valid cycle", first_v, 93);
      check("beat count", nbeats, NB);
      check("done pulses", ndone, 1);
      check("tile count", nfall, 4);
      for (int k = 0; k < 4; k++) check("sel order", sels[k], k);
    end else begin
      check("abort reached", fin, 1);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("no done after abort", done, 0);
        check("idle after abort", out_valid, 0);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst core_rst", core_rst, 1);
    check("rst sel", {sel1, sel2}, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst out_index", out_index, 0);
    check("rst out_data", out_data, 0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle core_rst", core_rst, 1);
      check("idle sel", {sel1, sel2}, 0);
      check("idle busy", busy, 0);
      check("idle out_valid", out_valid, 0);
    end
    do_pass(0, 0, 0);    // full pass, always ready
    do_pass(1, 0, 0);    // ready pattern 1,0,0
    do_pass(0, 1, 0);    // stray starts in RUN and DRAIN
    do_pass(0, 0, 55);   // rst in RUN of tile 2
    do_pass(0, 0, 0);    // fresh pass after abort
    do_pass(0, 0, 123);  // rst at drain index 30
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
